// File: rtl/fifo_sync_flags.sv
// fifo_sync_flags
// Synchronous single-clock FIFO with registered pointers. It provides full,
// empty and threshold flags, an entry count, and one-cycle overflow and
// underflow error pulses.
//
// Build option:
//   FIFO_SYNC_FWFT_EN  defined   -> first-word fall-through. o_rdata shows the
//                                   head entry whenever the FIFO is not empty.
//                      undefined -> o_rdata is a register. It loads the head
//                                   entry on the edge that accepts a read.
//
// Parameters:
//   DATA_WIDTH  entry width in bits
//   ADDR_WIDTH  log2 of the storage depth
//   AF_THRESH   o_almost_full  is set when fill >= AF_THRESH
//   AE_THRESH   o_almost_empty is set when fill <= AE_THRESH
//
// Ports:
//   i_clk           clock; all state changes on the rising edge
//   i_rstn          asynchronous active-low reset
//   i_wr / i_wdata  write request and write data
//   i_rd            read request (in FWFT mode: pop / acknowledge)
//   o_rdata         read data
//   o_full/o_empty  FIFO full / FIFO empty
//   o_almost_full   fill >= AF_THRESH
//   o_almost_empty  fill <= AE_THRESH
//   o_fill          number of stored entries, 0 .. 2**ADDR_WIDTH
//   o_overflow      pulses for one cycle after a rejected write
//   o_underflow     pulses for one cycle after a rejected read
module fifo_sync_flags #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int AF_THRESH  = 2**ADDR_WIDTH - 2,
  parameter int AE_THRESH  = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rstn,
  input  logic                  i_wr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic                  i_rd,
  output logic [DATA_WIDTH-1:0] o_rdata,
  output logic                  o_full,
  output logic                  o_empty,
  output logic                  o_almost_full,
  output logic                  o_almost_empty,
  output logic [ADDR_WIDTH:0]   o_fill,
  output logic                  o_overflow,
  output logic                  o_underflow
);

  localparam int PTR_W = ADDR_WIDTH + 1;
  localparam logic [PTR_W-1:0] AF_LVL = PTR_W'(AF_THRESH);
  localparam logic [PTR_W-1:0] AE_LVL = PTR_W'(AE_THRESH);

  // The pointers carry one extra wrap bit. This lets the logic tell a full
  // FIFO from an empty one when the address bits are equal.
  logic [PTR_W-1:0]      wptr;
  logic [PTR_W-1:0]      rptr;
  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
  logic                  wr_ok;
  logic                  rd_ok;

  // All flags come only from the registered pointers. Because of this, a
  // request affects the flags one cycle later and never through a
  // combinational path.
  assign o_empty        = (wptr == rptr);
  assign o_full         = (wptr[ADDR_WIDTH] != rptr[ADDR_WIDTH]) &&
                          (wptr[ADDR_WIDTH-1:0] == rptr[ADDR_WIDTH-1:0]);
  assign o_fill         = wptr - rptr;
  assign o_almost_full  = (o_fill >= AF_LVL);
  assign o_almost_empty = (o_fill <= AE_LVL);

  // The full and empty states are taken before this edge. So when the FIFO
  // is full, a read in the same cycle does not free space for the write.
  // When it is empty, a write in the same cycle does not supply data for
  // the read.
  assign wr_ok = i_wr && !o_full;
  assign rd_ok = i_rd && !o_empty;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      wptr        <= '0;
      rptr        <= '0;
      o_overflow  <= 1'b0;
      o_underflow <= 1'b0;
    end else begin
      if (wr_ok) wptr <= wptr + 1'b1;
      if (rd_ok) rptr <= rptr + 1'b1;
      o_overflow  <= i_wr && o_full;
      o_underflow <= i_rd && o_empty;
    end
  end

  // The storage array has no reset. Reset only clears the pointers, so old
  // contents can no longer be reached after reset.
  always_ff @(posedge i_clk) begin
    if (wr_ok) mem[wptr[ADDR_WIDTH-1:0]] <= i_wdata;
  end

`ifdef FIFO_SYNC_FWFT_EN
  // The output is forced to zero while the FIFO is empty. This keeps stale
  // or unwritten entries from ever appearing on o_rdata.
  assign o_rdata = o_empty ? '0 : mem[rptr[ADDR_WIDTH-1:0]];
`else
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn)    o_rdata <= '0;
    else if (rd_ok) o_rdata <= mem[rptr[ADDR_WIDTH-1:0]];
  end
`endif

endmodule

// File: tb/tb_fifo_sync_flags.sv
// tb_fifo_sync_flags
// Scoreboard bench for fifo_sync_flags. The FIFO is configured with
// DATA_WIDTH=8, ADDR_WIDTH=2, AF_THRESH=3 and AE_THRESH=1.
//
// The driver sets the inputs on the falling edge. It then updates a
// queue-based model of the FIFO and pushes the expected post-edge outputs
// into a queue. The monitor pops one entry shortly after each rising edge
// and compares it with the DUT. Reset behaviour is checked directly, while
// reset is held low.
module tb_fifo_sync_flags;

  localparam int DW    = 8;
  localparam int AW    = 2;
  localparam int DEPTH = 4;
  localparam int AF    = 3;
  localparam int AE    = 1;

  logic          clk = 1'b0;
  logic          i_rstn;
  logic          i_wr;
  logic [DW-1:0] i_wdata;
  logic          i_rd;
  logic [DW-1:0] o_rdata;
  logic          o_full;
  logic          o_empty;
  logic          o_almost_full;
  logic          o_almost_empty;
  logic [AW:0]   o_fill;
  logic          o_overflow;
  logic          o_underflow;

  typedef struct {
    int          fill;
    bit          full;
    bit          empty;
    bit          af;
    bit          ae;
    bit          ovf;
    bit          unf;
    logic [7:0]  rdata;
    bit          chk_rdata;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] model_q[$];
  logic [7:0] model_rdata;
  int         checks = 0;
  int         errors = 0;

  fifo_sync_flags #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .AF_THRESH (AF),
    .AE_THRESH (AE)
  ) dut (
    .i_clk         (clk),
    .i_rstn        (i_rstn),
    .i_wr          (i_wr),
    .i_wdata       (i_wdata),
    .i_rd          (i_rd),
    .o_rdata       (o_rdata),
    .o_full        (o_full),
    .o_empty       (o_empty),
    .o_almost_full (o_almost_full),
    .o_almost_empty(o_almost_empty),
    .o_fill        (o_fill),
    .o_overflow    (o_overflow),
    .o_underflow   (o_underflow)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, actual, expected);
    end
  endtask

  // Drive one cycle of stimulus and queue the outputs the DUT should show
  // after the next rising edge. The model is a plain queue: the FIFO is
  // full at DEPTH entries and empty at zero entries.
  task automatic applyStimulus(input bit wr, input bit rd, input logic [7:0] data);
    exp_t e;
    bit   was_full;
    bit   was_empty;
    @(negedge clk);
    i_wr    = wr;
    i_rd    = rd;
    i_wdata = data;
    was_full  = (model_q.size() == DEPTH);
    was_empty = (model_q.size() == 0);
    e.ovf = wr && was_full;
    e.unf = rd && was_empty;
    if (rd && !was_empty) model_rdata = model_q.pop_front();
    if (wr && !was_full)  model_q.push_back(data);
    e.fill  = model_q.size();
    e.full  = (model_q.size() == DEPTH);
    e.empty = (model_q.size() == 0);
    e.af    = (model_q.size() >= AF);
    e.ae    = (model_q.size() <= AE);
`ifdef FIFO_SYNC_FWFT_EN
    e.chk_rdata = (model_q.size() != 0);
    e.rdata     = (model_q.size() != 0) ? model_q[0] : 8'h00;
`else
    e.chk_rdata = 1'b1;
    e.rdata     = model_rdata;
`endif
    exp_q.push_back(e);
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, ".fill"},  int'(o_fill), 0);
    checkOutput({tag, ".empty"}, int'(o_empty), 1);
    checkOutput({tag, ".ae"},    int'(o_almost_empty), 1);
    checkOutput({tag, ".full"},  int'(o_full), 0);
    checkOutput({tag, ".af"},    int'(o_almost_full), 0);
    checkOutput({tag, ".rdata"}, int'(o_rdata), 0);
    checkOutput({tag, ".ovf"},   int'(o_overflow), 0);
    checkOutput({tag, ".unf"},   int'(o_underflow), 0);
  endtask

  // Assert reset between clock edges, check the cleared state immediately,
  // hold reset across one rising edge, and release it on a falling edge.
  task automatic applyReset(input string tag);
    @(negedge clk);
    i_wr = 1'b0;
    i_rd = 1'b0;
    #2 i_rstn = 1'b0;
    model_q.delete();
    model_rdata = 8'h00;
    #1 checkResetState(tag);
    @(negedge clk);
    i_rstn = 1'b1;
  endtask

  // Monitor: compare one queued expectation shortly after each rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput("fill",  int'(o_fill), e.fill);
        checkOutput("full",  int'(o_full), int'(e.full));
        checkOutput("empty", int'(o_empty), int'(e.empty));
        checkOutput("af",    int'(o_almost_full), int'(e.af));
        checkOutput("ae",    int'(o_almost_empty), int'(e.ae));
        checkOutput("ovf",   int'(o_overflow), int'(e.ovf));
        checkOutput("unf",   int'(o_underflow), int'(e.unf));
        if (e.chk_rdata) checkOutput("rdata", int'(o_rdata), int'(e.rdata));
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    i_rstn      = 1'b0;
    i_wr        = 1'b0;
    i_rd        = 1'b0;
    i_wdata     = '0;
    model_rdata = 8'h00;
    #2 checkResetState("por");
    @(negedge clk);
    i_rstn = 1'b1;

    $display("[TB] fill to full");
    applyStimulus(1, 0, 8'h11);
    applyStimulus(1, 0, 8'h22);
    applyStimulus(1, 0, 8'h33);
    applyStimulus(1, 0, 8'h44);

    $display("[TB] overflow then drain");
    applyStimulus(1, 0, 8'h55);
    applyStimulus(0, 0, 8'h00);
    for (int i = 0; i < 4; i++) applyStimulus(0, 1, 8'h00);
    applyStimulus(0, 0, 8'h00);

    $display("[TB] underflow on empty");
    applyStimulus(0, 1, 8'h00);
    applyStimulus(0, 0, 8'h00);
    applyStimulus(1, 1, 8'h66);
    applyStimulus(0, 1, 8'h00);

    $display("[TB] simultaneous write/read at fill 2");
    applyStimulus(1, 0, 8'h01);
    applyStimulus(1, 0, 8'h02);
    for (int i = 0; i < 6; i++) applyStimulus(1, 1, 8'(8'h10 + i));
    applyStimulus(1, 1, 8'hEE);
    for (int i = 0; i < 3; i++) applyStimulus(0, 1, 8'h00);

    $display("[TB] single entry fall-through");
    applyStimulus(1, 0, 8'hA5);
    applyStimulus(0, 0, 8'h00);
    applyStimulus(0, 1, 8'h00);
    applyStimulus(0, 0, 8'h00);

    $display("[TB] reset mid-operation");
    applyStimulus(1, 0, 8'hC1);
    applyStimulus(1, 0, 8'hC2);
    applyStimulus(1, 0, 8'hC3);
    applyReset("midrst");
    applyStimulus(1, 0, 8'h77);
    applyStimulus(0, 1, 8'h00);
    applyStimulus(0, 0, 8'h00);

    $display("[TB] random traffic");
    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(0, 99) < 55, $urandom_range(0, 99) < 50, 8'($urandom));
    end

    @(negedge clk);
    i_wr = 1'b0;
    i_rd = 1'b0;
    @(posedge clk);
    #2;
    checkOutput("drain", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fifo_sync_flags.md
FIFO_SYNC_FLAGS -- requirements
Module: fifo_sync_flags

Interface
REQ-001 Parameter DATA_WIDTH, default 8: width of each FIFO entry in bits.
REQ-002 Parameter ADDR_WIDTH, default 4: storage depth is 2**ADDR_WIDTH entries.
REQ-003 Parameter AF_THRESH, default 2**ADDR_WIDTH-2: o_almost_full asserts when fill >= AF_THRESH.
REQ-004 Parameter AE_THRESH, default 2: o_almost_empty asserts when fill <= AE_THRESH.
REQ-005 Port i_clk  in  1: single clock; all state updates on the rising edge.
REQ-006 Port i_rstn  in  1: reset, asynchronous and active-low.
REQ-007 Port i_wr  in  1: write request.
REQ-008 Port i_wdata  in  DATA_WIDTH: write data, sampled with i_wr.
REQ-009 Port i_rd  in  1: read request.
REQ-010 Port o_rdata  out  DATA_WIDTH: read data.
REQ-011 Port o_full / o_empty  out  1 each: FIFO full / FIFO empty.
REQ-012 Port o_almost_full / o_almost_empty  out  1 each: threshold flags.
REQ-013 Port o_fill  out  ADDR_WIDTH+1: current entry count, 0 to 2**ADDR_WIDTH.
REQ-014 Port o_overflow / o_underflow  out  1 each: one-cycle error pulses.

Function
REQ-015 Write accepted iff i_wr=1 and o_full=0; data stored at the write pointer, which then increments.
REQ-016 Read accepted iff i_rd=1 and o_empty=0; the read pointer increments.
REQ-017 Pointers are ADDR_WIDTH+1 bits, wrapping modulo 2**(ADDR_WIDTH+1); the low ADDR_WIDTH bits address memory.
REQ-018 Empty: pointers equal. Full: MSBs differ and low bits equal.
REQ-019 o_fill equals wptr-rptr, modulo 2**(ADDR_WIDTH+1).
REQ-020 All flags and o_fill derive from registered pointers only; there is no combinational path from i_wr or i_rd to any flag.
REQ-021 Flags and o_fill reflect an accepted operation in the cycle after its edge.
REQ-022 Simultaneous write and read when neither full nor empty: both accepted, o_fill unchanged.
REQ-023 When full, a write is rejected even if a read occurs in the same cycle.
REQ-024 When empty, a read is rejected even if a write occurs in the same cycle.
REQ-025 Rejected write (i_wr=1, o_full=1): memory and pointers unchanged; o_overflow=1 for the next cycle only.
REQ-026 Rejected read (i_rd=1, o_empty=1): pointers and o_rdata unchanged; o_underflow=1 for the next cycle only.
REQ-027 Memory is not reset; contents are never visible before being written.

Reset
REQ-028 While i_rstn=0, regardless of clock: both pointers=0, o_empty=1, o_almost_empty=1, o_full=0, o_almost_full=0, o_fill=0, o_rdata=0, o_overflow=0, o_underflow=0.
REQ-029 Reset asserted mid-operation discards all contents immediately; a write or read request in the release cycle follows REQ-015/016 normally.

Configuration
REQ-030 Macro FIFO_SYNC_FWFT_EN selects first-word fall-through mode.
REQ-031 FIFO_SYNC_FWFT_EN undefined: o_rdata is registered; the head entry appears on the edge that accepts a read and holds until the next accepted read.
REQ-032 FIFO_SYNC_FWFT_EN defined: o_rdata always shows the head entry while o_empty=0; i_rd acknowledges and pops it; the next entry appears the cycle after the pop; o_rdata is don't-care while empty.

Verification
(All scenarios: DATA_WIDTH=8, ADDR_WIDTH=2, AF_THRESH=3, AE_THRESH=1.)
REQ-033 Reset, then write 0x11,0x22,0x33,0x44 -> o_fill 1,2,3,4; o_almost_full at fill 3; o_full at fill 4; o_empty=0 from the cycle after the first write.
REQ-034 Full FIFO, write 0x55 -> o_overflow pulses one cycle; four reads return 0x11,0x22,0x33,0x44 (standard mode: one cycle after each accepted read); o_empty=1 afterwards.
REQ-035 Empty FIFO, i_rd=1 -> o_underflow pulses one cycle; o_rdata and o_fill unchanged.
REQ-036 Fill 2 with simultaneous write+read for 6 cycles -> o_fill stays 2, pointers wrap past 7, data order preserved.
REQ-037 FWFT build: write 0xA5 into empty FIFO -> o_empty=0 and o_rdata=0xA5 the next cycle with no i_rd; i_rd pops it and o_empty=1 the following cycle.
REQ-038 Fill 3 then assert i_rstn=0 between edges -> o_fill=0, o_empty=1, o_rdata=0 immediately; first post-reset write is read back correctly.
